gate_sync: RTL and testbench

//  Responder side of the gate enable/sync handshake. Takes the gate_en vector from the

---
 rtl/gate_pkg.sv | 16 +
 rtl/gate_sync_lane.sv | 104 ++++++++++
 rtl/gate_sync.sv | 49 ++++
 tb/tb_gate_sync.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared constants and lane state encoding for the gate enable/sync handshake.
// Widths here must match the startup sequencer.
package gate_pkg;

  localparam int N_GATE = 5;
  localparam int CNT_W  = 32;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    SETTLE   = 3'd1,
    WAIT_RDY = 3'd2,
    ON       = 3'd3,
    ERR      = 3'd4
  } lane_state_t;

endpackage

// File: rtl/gate_sync_lane.sv
// One gate lane: settle timer, ready wait with optional timeout, and fault latch.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  OFF      | lane disabled, outputs low, counter cleared
//  SETTLE   | counting latched settle cycles after enable rise
//  WAIT_RDY | waiting for downstream ready, optional timeout
//  ON       | lane up, sync high while ready holds
//  ERR      | timeout or ready drop; sticky until enable falls
module gate_sync_lane
  import gate_pkg::*;
#(
  parameter int CNT_W = gate_pkg::CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             rdy_i,
  input  logic [CNT_W-1:0] settle_i,
  input  logic [CNT_W-1:0] timeout_i,
  output logic             sync_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lane_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic             sync_q, err_q;
  logic [CNT_W-1:0] timeout_last;

  // Timeout fires on the T-th WAIT_RDY cycle without ready.
  assign timeout_last = timeout_i - CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    if (!en_i) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d  = SETTLE;
          cnt_d    = '0;
          settle_d = settle_i;
        end
        SETTLE: begin
          if (cnt_q == settle_q) begin
            state_d = WAIT_RDY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_RDY: begin
          if (rdy_i) begin
            state_d = ON;
          end else if ((timeout_i != '0) && (cnt_q == timeout_last)) begin
            state_d = ERR;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ON: begin
          if (!rdy_i) begin
            state_d = ERR;
          end
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      settle_q <= '0;
      sync_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      sync_q   <= (state_d == ON);
      err_q    <= (state_d == ERR);
    end
  end

  assign sync_o = sync_q;
  assign err_o  = err_q;
  assign busy_o = (state_q == SETTLE) || (state_q == WAIT_RDY);

endmodule

// File: rtl/gate_sync.sv
// Responder side of the gate enable/sync handshake: one independent lane per gate,
// sync echoes enable once each lane is settled and ready.
module gate_sync
  import gate_pkg::*;
#(
  parameter int N_GATE = gate_pkg::N_GATE,
  parameter int CNT_W  = gate_pkg::CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_GATE-1:0] gate_en_i,
  input  logic [N_GATE-1:0] gate_rdy_i,
  input  logic [CNT_W-1:0]  gate_settle_i,
  input  logic [CNT_W-1:0]  gate_timeout_i,
  output logic [N_GATE-1:0] gate_sync_o,
  output logic [N_GATE-1:0] gate_err_o,
  output logic              gate_busy_o
);

  logic [N_GATE-1:0] lane_busy;
  logic              busy_q;

  for (genvar k = 0; k < N_GATE; k++) begin : g_lane
    gate_sync_lane #(
      .CNT_W (CNT_W)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .en_i      (gate_en_i[k]),
      .rdy_i     (gate_rdy_i[k]),
      .settle_i  (gate_settle_i),
      .timeout_i (gate_timeout_i),
      .sync_o    (gate_sync_o[k]),
      .err_o     (gate_err_o[k]),
      .busy_o    (lane_busy[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= |lane_busy;
    end
  end

  assign gate_busy_o = busy_q;

endmodule

// File: tb/tb_gate_sync.sv
// Directed bench for gate_sync: settle latency, timeout, ready drop, disable echo,
// closed-loop sequencing and async reset.
module tb_gate_sync;

  localparam int NG = 5;
  localparam int CW = 32;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [NG-1:0] gate_en_i = '0;
  logic [NG-1:0] gate_rdy_i = '0;
  logic [CW-1:0] gate_settle_i = '0;
  logic [CW-1:0] gate_timeout_i = '0;
  logic [NG-1:0] gate_sync_o;
  logic [NG-1:0] gate_err_o;
  logic          gate_busy_o;

  int n_checks = 0;
  int n_errors = 0;

  gate_sync dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .gate_en_i      (gate_en_i),
    .gate_rdy_i     (gate_rdy_i),
    .gate_settle_i  (gate_settle_i),
    .gate_timeout_i (gate_timeout_i),
    .gate_sync_o    (gate_sync_o),
    .gate_err_o     (gate_err_o),
    .gate_busy_o    (gate_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [NG-1:0] exp_en;
  int            waited;

  initial begin
    // reset
    step(2);
    chk("rst_sync", 32'(gate_sync_o), 32'h0);
    chk("rst_err", 32'(gate_err_o), 32'h0);
    chk("rst_busy", 32'(gate_busy_o), 32'h0);
    rst_n_i = 1'b1;
    step(1);

    // 1: S=3, T=0, lane 0 ready; sync at edge 5
    gate_settle_i = 32'd3; gate_timeout_i = 32'd0;
    gate_rdy_i = 5'b00001; gate_en_i = 5'b00001;
    step(1);
    chk("t1_busy_e0", 32'(gate_busy_o), 32'h0);
    step(1);
    chk("t1_busy_e1", 32'(gate_busy_o), 32'h1);
    step(3);
    chk("t1_busy_e4", 32'(gate_busy_o), 32'h1);
    chk("t1_sync_e4", 32'(gate_sync_o), 32'h0);
    step(1);
    chk("t1_sync_e5", 32'(gate_sync_o), 32'h01);
    step(2);
    chk("t1_busy_idle", 32'(gate_busy_o), 32'h0);
    gate_en_i = '0;
    step(1);
    chk("t1_off_echo", 32'(gate_sync_o), 32'h0);

    // 2: S=0, T=4; lane 1 never ready -> err after 4 wait cycles
    gate_settle_i = 32'd0; gate_timeout_i = 32'd4;
    gate_rdy_i = 5'b00001; gate_en_i = 5'b00011;
    step(3);
    chk("t2_sync_e2", 32'(gate_sync_o), 32'h01);
    step(2);
    chk("t2_err_e4", 32'(gate_err_o), 32'h0);
    step(1);
    chk("t2_err_e5", 32'(gate_err_o), 32'h02);
    step(5);
    chk("t2_sync_hold", 32'(gate_sync_o), 32'h01);
    chk("t2_err_hold", 32'(gate_err_o), 32'h02);
    gate_en_i = '0;
    step(1);
    chk("t2_err_clr", 32'(gate_err_o), 32'h0);
    chk("t2_sync_clr", 32'(gate_sync_o), 32'h0);

    // 3: S=10, enable dropped mid-SETTLE
    gate_settle_i = 32'd10; gate_timeout_i = 32'd0;
    gate_rdy_i = 5'b00001; gate_en_i = 5'b00001;
    step(4);
    gate_en_i = '0;
    step(15);
    chk("t3_sync", 32'(gate_sync_o), 32'h0);
    chk("t3_err", 32'(gate_err_o), 32'h0);
    chk("t3_busy", 32'(gate_busy_o), 32'h0);

    // 4: lane 2, S=2 latched (later change ignored); ready drop -> sticky err
    gate_settle_i = 32'd2; gate_rdy_i = 5'b00100; gate_en_i = 5'b00100;
    step(1);
    gate_settle_i = 32'd20;
    step(3);
    chk("t4_sync_e3", 32'(gate_sync_o), 32'h0);
    step(1);
    chk("t4_sync_e4", 32'(gate_sync_o), 32'h04);
    gate_rdy_i = '0;
    step(1);
    chk("t4_drop_sync", 32'(gate_sync_o), 32'h0);
    chk("t4_drop_err", 32'(gate_err_o), 32'h04);
    gate_rdy_i = 5'b00100;
    step(3);
    chk("t4_hold_sync", 32'(gate_sync_o), 32'h0);
    chk("t4_hold_err", 32'(gate_err_o), 32'h04);
    gate_en_i = '0;
    step(1);
    chk("t4_clr_err", 32'(gate_err_o), 32'h0);

    // T=1 faults after one wait cycle; re-enable restarts cleanly
    gate_settle_i = 32'd0; gate_timeout_i = 32'd1;
    gate_rdy_i = '0; gate_en_i = 5'b01000;
    step(2);
    chk("t1to_err_e1", 32'(gate_err_o), 32'h0);
    step(1);
    chk("t1to_err_e2", 32'(gate_err_o), 32'h08);
    gate_en_i = '0;
    step(1);
    gate_timeout_i = 32'd0; gate_rdy_i = 5'b01000; gate_en_i = 5'b01000;
    step(3);
    chk("reen_sync", 32'(gate_sync_o), 32'h08);
    chk("reen_err", 32'(gate_err_o), 32'h0);
    gate_en_i = '0;
    step(1);

    // ready rise beats timeout compare in the same cycle
    gate_timeout_i = 32'd2; gate_rdy_i = '0; gate_en_i = 5'b10000;
    step(3);
    gate_rdy_i = 5'b10000;
    step(1);
    chk("rdy_vs_to_sync", 32'(gate_sync_o), 32'h10);
    chk("rdy_vs_to_err", 32'(gate_err_o), 32'h0);
    gate_en_i = '0; gate_timeout_i = 32'd0;
    step(1);

    // 5: closed loop, S=1, shift delay 2
    gate_settle_i = 32'd1; gate_rdy_i = 5'b11111;
    exp_en = 5'b00001;
    gate_en_i = exp_en;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (gate_sync_o !== exp_en && waited < 20) begin
        step(1);
        waited++;
      end
      chk("t5_sync_track", 32'(gate_sync_o), 32'(exp_en));
      chk("t5_no_err", 32'(gate_err_o), 32'h0);
      step(2);
      exp_en = {exp_en[NG-2:0], 1'b1};
      if (i < 3) gate_en_i = exp_en;
    end
    gate_en_i = '0;
    step(1);
    chk("t5_off", 32'(gate_sync_o), 32'h0);

    // 6: async reset while lanes 2-4 wait and lanes 0-1 are up
    gate_settle_i = 32'd2; gate_rdy_i = 5'b00011; gate_en_i = 5'b11111;
    step(6);
    chk("t6_pre_sync", 32'(gate_sync_o), 32'h03);
    chk("t6_pre_busy", 32'(gate_busy_o), 32'h1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("t6_rst_sync", 32'(gate_sync_o), 32'h0);
    chk("t6_rst_err", 32'(gate_err_o), 32'h0);
    chk("t6_rst_busy", 32'(gate_busy_o), 32'h0);
    @(negedge clk_i);
    gate_rdy_i = 5'b11111;
    rst_n_i = 1'b1;
    step(2);
    chk("t6_restart_busy", 32'(gate_busy_o), 32'h1);
    step(2);
    chk("t6_sync_e3", 32'(gate_sync_o), 32'h0);
    step(1);
    chk("t6_sync_e4", 32'(gate_sync_o), 32'h1f);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
